mem_port_arb: RTL and testbench

- Arbiter and sequencer for the single shared 64-bit memory port of the 5-stage pipeline.
- Two requesters share the port:
  - port 0: instruction fetch, read-only.
  - port 1: MEM stage, read/write.
- Drives the select of the 64-bit 2:1 address/data mux in front of the memory and runs the request/acknowledge handshake with the memory.
- Priority goes to port 1; a starvation guard and an ack timeout are included.

---
 rtl/mem_port_arb_if.sv | 35 +++
 rtl/mem_port_arb.sv | 121 ++++++++++++
 tb/tb_mem_port_arb.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_if.sv
// Bundle of requester, memory and status signals around the shared memory port.
interface mem_port_arb_if;
    logic        req0;
    logic [63:0] addr0;
    logic        req1;
    logic        we1;
    logic [63:0] addr1;
    logic [63:0] wdata1;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        sel;
    logic        done0;
    logic        done1;
    logic [63:0] rdata;
    logic        err;
    logic        busy;

    modport slave (
        input  req0, addr0, req1, we1, addr1, wdata1,
        input  mem_ack, mem_rdata,
        output mem_req, mem_addr, mem_we, mem_wdata,
        output sel, done0, done1, rdata, err, busy
    );

    modport master (
        output req0, addr0, req1, we1, addr1, wdata1,
        output mem_ack, mem_rdata,
        input  mem_req, mem_addr, mem_we, mem_wdata,
        input  sel, done0, done1, rdata, err, busy
    );
endinterface

// File: rtl/mem_port_arb.sv
// Two-port arbiter/sequencer for the shared 64-bit memory port:
// port 1 (MEM) has priority, bounded by a starvation guard and an ack timeout.
module mem_port_arb #(
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_arb_if.slave  bus
);
    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [63:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          win1;

    assign win1 = bus.req1 && ((starve_q < STARVE_MAX) || !bus.req0);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        starve_d = starve_q;
        tcnt_d   = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (win1) begin
                    state_d = BUSY;
                    tcnt_d  = '0;
                    sel_d   = 1'b1;
                    addr_d  = bus.addr1;
                    we_d    = bus.we1;
                    wdata_d = bus.wdata1;
                    // Only a grant that bypasses a waiting fetch counts.
                    if (!bus.req0)
                        starve_d = '0;
                    else if (starve_q != STARVE_MAX)
                        starve_d = starve_q + 1'b1;
                end else if (bus.req0) begin
                    state_d  = BUSY;
                    tcnt_d   = '0;
                    sel_d    = 1'b0;
                    addr_d   = bus.addr0;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    starve_d = '0;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (tcnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            starve_q <= starve_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign bus.mem_req   = (state_q == BUSY);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done0     = (state_q == DONE) && !sel_q;
    assign bus.done1     = (state_q == DONE) && sel_q;
    assign bus.sel       = sel_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed and randomized bench for mem_port_arb with a transaction-level
// reference model of the arbitration order and handshake outcome.
module tb_mem_port_arb;
    logic clk;
    logic rst;
    mem_port_arb_if bus();

    mem_port_arb #(.MAX_STARVE(4), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          p0, p1;
    int          starve_m;
    logic [63:0] a0, a1, d1;
    bit          w1;
    int          force_dly;
    bit          fix_rd;
    logic [63:0] fixed_rd;
    bit          grants[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new0();
        a0 = {$urandom, $urandom};
        bus.addr0 = a0;
    endtask

    task automatic new1();
        a1 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        w1 = 1'($urandom);
        bus.addr1 = a1;
        bus.we1 = w1;
        bus.wdata1 = d1;
    endtask

    task automatic serve(input bit port, input logic [63:0] ea,
                         input bit ewe, input logic [63:0] ewd,
                         input int dly, input logic [63:0] rd);
        int n;
        int hold;
        logic [63:0] exp_rd;
        bit exp_err;
        n = 0;
        while (!bus.mem_req && n < 6) begin
            tick();
            n++;
        end
        chk("grant_seen", bus.mem_req, 1'b1);
        chk("sel", bus.sel, port);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_we", bus.mem_we, ewe);
        chk("mem_wdata", bus.mem_wdata, ewd);
        chk("busy_in_busy", bus.busy, 1'b1);
        if (dly < 16) begin
            hold = 0;
            for (int i = 0; i < dly; i++) begin
                tick();
                if (bus.mem_req) hold++;
            end
            chk("req_held", hold, dly);
            chk("addr_stable", bus.mem_addr, ea);
            bus.mem_ack = 1'b1;
            bus.mem_rdata = rd;
            tick();
            bus.mem_ack = 1'b0;
            bus.mem_rdata = {$urandom, $urandom};
            exp_rd = rd;
            exp_err = 1'b0;
        end else begin
            n = 1;
            while (bus.mem_req && n < 40) begin
                tick();
                if (bus.mem_req) n++;
            end
            chk("timeout_cycles", n, 16);
            exp_rd = '0;
            exp_err = 1'b1;
        end
        chk("done0", bus.done0, !port);
        chk("done1", bus.done1, port);
        chk("rdata", bus.rdata, exp_rd);
        chk("err", bus.err, exp_err);
        chk("req_low_done", bus.mem_req, 1'b0);
    endtask

    // Serves all pending requests; 'reassert' re-issues port 1 after its
    // done while a fetch is still waiting, to push on the starvation guard.
    task automatic run_all(input int reassert);
        bit win;
        int dly;
        logic [63:0] rd;
        while (p0 || p1) begin
            win = p1 && (starve_m < 4 || !p0);
            if (win) starve_m = p0 ? ((starve_m < 4) ? starve_m + 1 : 4) : 0;
            else starve_m = 0;
            grants.push_back(win);
            dly = (force_dly >= 0) ? force_dly :
                  (($urandom % 10 == 0) ? 16 : int'($urandom % 5));
            rd = fix_rd ? fixed_rd : {$urandom, $urandom};
            if (win) serve(1'b1, a1, w1, d1, dly, rd);
            else serve(1'b0, a0, 1'b0, 64'd0, dly, rd);
            if (win && p0 && reassert > 0) begin
                reassert--;
                new1();
            end else if (win) begin
                p1 = 0;
                bus.req1 = 1'b0;
            end else begin
                p0 = 0;
                bus.req0 = 1'b0;
            end
            tick();
            chk("idle_busy", bus.busy, 1'b0);
            chk("idle_done", {bus.done0, bus.done1}, 2'b00);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.we1 = 1'b0;
        bus.wdata1 = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        p0 = 0;
        p1 = 0;
        starve_m = 0;
        force_dly = -1;
        fix_rd = 0;
        fixed_rd = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_sel", bus.sel, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_err_done", {bus.err, bus.done0, bus.done1}, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single fetch
        a0 = 64'hF0F0F0F0F0F0F0F0;
        bus.addr0 = a0;
        bus.req0 = 1'b1;
        p0 = 1;
        force_dly = 2;
        fix_rd = 1;
        fixed_rd = 64'hFFFFFFFFFFFFFFFF;
        run_all(0);
        fix_rd = 0;

        // simultaneous requests
        grants.delete();
        new0();
        a1 = 64'd0;
        d1 = 64'h1234;
        w1 = 1'b1;
        bus.addr1 = a1;
        bus.we1 = w1;
        bus.wdata1 = d1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        p0 = 1;
        p1 = 1;
        force_dly = 0;
        run_all(0);
        chk("simul_order", {grants.size(), grants[0], grants[1]},
            {32'd2, 1'b1, 1'b0});

        // starvation guard
        grants.delete();
        new0();
        new1();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        p0 = 1;
        p1 = 1;
        force_dly = 1;
        run_all(4);
        chk("starve_cnt", grants.size(), 6);
        chk("starve_seq", {grants[0], grants[1], grants[2], grants[3],
                           grants[4], grants[5]}, 6'b111101);
        grants.delete();
        new0();
        new1();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        p0 = 1;
        p1 = 1;
        run_all(0);
        chk("regain_prio", grants[0], 1'b1);

        // ack timeout
        new1();
        bus.req1 = 1'b1;
        p1 = 1;
        force_dly = 16;
        run_all(0);

        // spurious ack in IDLE
        bus.mem_ack = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
        tick();
        bus.mem_ack = 1'b0;
        chk("spur_busy", bus.busy, 1'b0);
        chk("spur_done", {bus.done0, bus.done1, bus.mem_req}, 3'b000);
        tick();
        chk("spur_busy2", bus.busy, 1'b0);

        // reset during BUSY
        new1();
        bus.req1 = 1'b1;
        tick();
        tick();
        chk("pre_rst_req", {bus.mem_req, bus.sel}, 2'b11);
        tick();
        rst = 1'b1;
        #1;
        chk("async_mem_req", bus.mem_req, 1'b0);
        chk("async_sel", bus.sel, 1'b0);
        chk("async_busy", bus.busy, 1'b0);
        bus.req1 = 1'b0;
        starve_m = 0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_no_done", {bus.done0, bus.done1, bus.busy}, 3'b000);
        new0();
        bus.req0 = 1'b1;
        p0 = 1;
        force_dly = 1;
        run_all(0);

        // randomized traffic
        force_dly = -1;
        for (int it = 0; it < 40; it++) begin
            p0 = 1'($urandom);
            p1 = 1'($urandom);
            if (!p0 && !p1) p1 = 1;
            new0();
            new1();
            bus.req0 = p0;
            bus.req1 = p1;
            run_all(int'($urandom % 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
